// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU sharing sequencer: widths, ALU opcodes and FSM encodings.
package alu_share_ctrl_pkg;

  localparam int INTERNAL_BITS = 16;
  localparam int ALUOP_BITS    = 4;

  localparam logic [ALUOP_BITS-1:0] OP_AND = 4'b0000;
  localparam logic [ALUOP_BITS-1:0] OP_OR  = 4'b0001;
  localparam logic [ALUOP_BITS-1:0] OP_ADD = 4'b0010;
  localparam logic [ALUOP_BITS-1:0] OP_SUB = 4'b0110;
  localparam logic [ALUOP_BITS-1:0] OP_SLT = 4'b0111;
  localparam logic [ALUOP_BITS-1:0] OP_NOR = 4'b1100;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

  function automatic logic op_legal(input logic [ALUOP_BITS-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin picker: first requester set at or after (ptr+1) mod NREQ, with wrap.
module alu_share_ctrl_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_req
);

  logic [IDW-1:0] cand;

  // Walk farthest-first so the closest candidate after ptr is the last one written.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    any_req   = |req;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between NREQ requesters; results return tagged with the requester id.
//   state | meaning
//   IDLE  | arbitrate; accept the winner and register its operands onto the ALU
//   EXEC  | ALU evaluates registered inputs; capture result/zero or flag an illegal op
//   RESP  | hold the response until rsp_ready
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = INTERNAL_BITS,
  parameter int OPW  = ALUOP_BITS,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  output logic [DW-1:0]     alu_in1,
  output logic [DW-1:0]     alu_in2,
  output logic [OPW-1:0]    alu_op,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_req;

  alu_share_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Grant is only offered while idle and out of reset, so nothing is accepted during a response.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state == EXEC) || (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NREQ - 1);
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_op   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_op  <= req_op[int'(grant_idx)*OPW +: OPW];
            alu_in1 <= req_a[int'(grant_idx)*DW +: DW];
            alu_in2 <= req_b[int'(grant_idx)*DW +: DW];
            rsp_id  <= grant_idx;
            rr_ptr  <= grant_idx;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (op_legal(alu_op)) begin
            rsp_data <= alu_result;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized scoreboard bench for alu_share_ctrl with a behavioural ALU and arbitration model.
module tb_alu_share_ctrl;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int OPW   = 4;
  localparam int IDW   = 2;
  localparam int LIMIT = 20000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OPW-1:0]  req_op;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [DW-1:0]        alu_in1, alu_in2, alu_result;
  logic [OPW-1:0]       alu_op;
  logic                 alu_zero;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [IDW-1:0]       rsp_id;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_zero, rsp_err, busy;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Stand-in ALU; unsupported codes produce a nonzero result with zero=1 so leakage is visible.
  function automatic logic [DW:0] alu_fn(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic z;
    z = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      4'b1100: r = ~(a | b);
      default: begin r = 16'hDEAD; z = 1'b1; end
    endcase
    if (r == '0) z = 1'b1;
    return {z, r};
  endfunction

  assign {alu_zero, alu_result} = alu_fn(alu_op, alu_in1, alu_in2);

  typedef struct {
    int            id;
    logic [OPW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] data;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  // stimulus-side state
  logic [NREQ-1:0] pend = '0;
  logic [OPW-1:0]  p_op [NREQ];
  logic [DW-1:0]   p_a  [NREQ];
  logic [DW-1:0]   p_b  [NREQ];
  bit              reload = 1'b0;
  bit              rand_mode = 1'b0;
  bit              done = 1'b0;
  int              to_err = 0;
  int              acc_done [NREQ];

  // monitor-side state
  int              n_tests = 0;
  int              n_fail = 0;
  int              phase = 0;
  int              rr = NREQ - 1;
  int              acc_seen [NREQ];
  int              rsp_cnt = 0;
  int              cyc_m = 0;
  int              win;
  bit              hold = 1'b0;
  logic [NREQ-1:0] exp_rdy;
  logic [IDW-1:0]  h_id;
  logic [DW-1:0]   h_data;
  logic            h_zero, h_err;
  exp_t            e;
  logic [DW:0]     fz;

  assign req_valid = pend;
  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*OPW +: OPW] = p_op[i];
      req_a[i*DW +: DW]    = p_a[i];
      req_b[i*DW +: DW]    = p_b[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_alu_in1", 32'(alu_in1), 32'(0));
      chk("rst_alu_in2", 32'(alu_in2), 32'(0));
      chk("rst_alu_op", 32'(alu_op), 32'(0));
      chk("rst_rsp_id", 32'(rsp_id), 32'(0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(0));
      chk("rst_rsp_zero", 32'(rsp_zero), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
      phase = 0;
      rr    = NREQ - 1;
      hold  = 1'b0;
      exp_q.delete();
    end else begin
      cyc_m++;
      if (done || cyc_m > LIMIT) begin
        if (!done) chk("watchdog_finished", 32'(0), 32'(1));
        chk("bounded_waits", 32'(to_err), 32'(0));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      win = -1;
      exp_rdy = '0;
      if (phase == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (win < 0 && req_valid[(rr + k) % NREQ]) win = (rr + k) % NREQ;
        end
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(phase == 2));
      case (phase)
        1: begin
          if (exp_q.size() > 0) begin
            chk("alu_op", 32'(alu_op), 32'(exp_q[0].op));
            chk("alu_in1", 32'(alu_in1), 32'(exp_q[0].a));
            chk("alu_in2", 32'(alu_in2), 32'(exp_q[0].b));
          end
          phase = 2;
          hold  = 1'b0;
        end
        2: begin
          if (hold) begin
            chk("hold_id", 32'(rsp_id), 32'(h_id));
            chk("hold_data", 32'(rsp_data), 32'(h_data));
            chk("hold_zero", 32'(rsp_zero), 32'(h_zero));
            chk("hold_err", 32'(rsp_err), 32'(h_err));
          end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              chk("rsp_unexpected", 32'(1), 32'(0));
            end else begin
              e = exp_q.pop_front();
              chk("rsp_id", 32'(rsp_id), 32'(e.id));
              chk("rsp_data", 32'(rsp_data), 32'(e.data));
              chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            rsp_cnt++;
            phase = 0;
            hold  = 1'b0;
          end else begin
            hold   = 1'b1;
            h_id   = rsp_id;
            h_data = rsp_data;
            h_zero = rsp_zero;
            h_err  = rsp_err;
          end
        end
        default: begin
          if (win >= 0) begin
            e.id = win;
            e.op = req_op[win*OPW +: OPW];
            e.a  = req_a[win*DW +: DW];
            e.b  = req_b[win*DW +: DW];
            if (e.op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100}) begin
              fz     = alu_fn(e.op, e.a, e.b);
              e.data = fz[DW-1:0];
              e.zero = fz[DW];
              e.err  = 1'b0;
            end else begin
              e.data = '0;
              e.zero = 1'b0;
              e.err  = 1'b1;
            end
            exp_q.push_back(e);
            rr    = win;
            phase = 1;
            acc_seen[win]++;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [OPW-1:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

  task automatic new_txn(input int i);
    pend[i] = 1'b1;
    p_op[i] = ($urandom_range(0, 4) == 0) ? OPW'($urandom) : legal_ops[$urandom_range(0, 5)];
    p_a[i]  = DW'($urandom);
    p_b[i]  = ($urandom_range(0, 7) == 0) ? p_a[i] : DW'($urandom);
  endtask

  task automatic set_txn(input int i, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_seen[i] != acc_done[i]) begin
        acc_done[i] = acc_seen[i];
        if (reload) new_txn(i);
        else pend[i] = 1'b0;
      end else if (rand_mode) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) new_txn(i);
        else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
    end
    if (rand_mode) rsp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_rsp(input int target, input int bound);
    int n = 0;
    while (rsp_cnt < target && n < bound) begin
      step();
      n++;
    end
    if (rsp_cnt < target) to_err++;
  endtask

  task automatic drain();
    int n = 0;
    pend = '0;
    rsp_ready = 1'b1;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (busy) to_err++;
    step();
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < NREQ; i++) begin
      p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
      acc_done[i] = 0; acc_seen[i] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // single request
    set_txn(0, 4'b0010, 16'h0003, 16'h0004);
    base = rsp_cnt;
    wait_rsp(base + 1, 20);
    drain();

    // round robin with continuous requests
    reload = 1'b1;
    for (int i = 0; i < NREQ; i++) new_txn(i);
    base = rsp_cnt;
    wait_rsp(base + 6, 60);
    reload = 1'b0;
    drain();

    // backpressure
    rsp_ready = 1'b0;
    new_txn(1);
    new_txn(3);
    n = 0;
    while (!rsp_valid && n < 10) begin step(); n++; end
    if (!rsp_valid) to_err++;
    repeat (5) step();
    rsp_ready = 1'b1;
    base = rsp_cnt;
    wait_rsp(base + 2, 30);
    drain();

    // illegal op on requester 2
    set_txn(2, 4'b1111, DW'($urandom), DW'($urandom));
    base = rsp_cnt;
    wait_rsp(base + 1, 20);
    drain();

    // zero flag pass-through
    set_txn(0, 4'b0110, 16'h1234, 16'h1234);
    base = rsp_cnt;
    wait_rsp(base + 1, 20);
    drain();

    // async reset while in EXEC
    new_txn(3);
    n = 0;
    while (!busy && n < 10) begin step(); n++; end
    if (!busy) to_err++;
    #1 rst_n = 1'b0;
    new_txn(1);
    new_txn(0);
    step();
    step();
    rst_n = 1'b1;
    base = rsp_cnt;
    wait_rsp(base + 2, 30);
    drain();

    // randomized traffic with withdrawals and backpressure
    rand_mode = 1'b1;
    repeat (600) step();
    rand_mode = 1'b0;
    drain();

    done = 1'b1;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer that time-shares the single 16-bit combinational ALU between NREQ requesters.
- Each requester presents one {op, operand1, operand2} transaction over a valid/ready handshake.
- The block arbitrates round-robin, registers the winner's operands onto the ALU inputs, captures the result, and returns it tagged with the requester id.
- It sits between instruction/issue sources and the ALU datapath. It drives the ALU's Data_in1, Data_in2 and ALUop and reads Result and Zero.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, data width; equals `INTERNAL_BITS.
- OPW, 4, opcode width; equals `ALUOP_BITS.
- IDW, 2, requester id width; equals clog2(NREQ).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- req_valid, input, NREQ, per-requester transaction valid.
- req_ready, output, NREQ, one-hot grant/accept; combinational, asserted only in IDLE.
- req_op, input, NREQ*OPW, flattened opcodes; requester i occupies bits [i*OPW +: OPW].
- req_a, input, NREQ*DW, flattened operand 1.
- req_b, input, NREQ*DW, flattened operand 2.
- alu_in1, output, DW, to ALU Data_in1 (registered).
- alu_in2, output, DW, to ALU Data_in2 (registered).
- alu_op, output, OPW, to ALU ALUop (registered).
- alu_result, input, DW, from ALU Result.
- alu_zero, input, 1, from ALU Zero.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumer ready.
- rsp_id, output, IDW, id of the requester being answered.
- rsp_data, output, DW, captured result.
- rsp_zero, output, 1, captured zero flag.
- rsp_err, output, 1, opcode was unsupported.
- busy, output, 1, high in EXEC or RESP.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=NREQ-1 (requester 0 has first priority).
- Reset clears alu_in1, alu_in2, alu_op, rsp_id, rsp_data, rsp_zero, rsp_err, rsp_valid and busy to 0, and req_ready to 0.
- Reset asserted mid-transaction discards the in-flight transaction; no response is produced.

State machine:
- IDLE:
  - If any req_valid is high, grant g = first set bit searching (rr_ptr+1) mod NREQ upward with wrap.
  - req_ready[g]=1 for that cycle only; all other req_ready bits are 0.
  - On the edge: latch req_op[g], req_a[g], req_b[g] into alu_op, alu_in1, alu_in2; rsp_id<=g; rr_ptr<=g; go to EXEC.
  - If no req_valid is high, stay in IDLE; req_ready=0.
- EXEC (exactly 1 cycle):
  - The ALU evaluates the registered inputs combinationally.
  - On the edge: rsp_data<=alu_result, rsp_zero<=alu_zero, rsp_err<=0, and go to RESP.
  - If the latched opcode is not in the legal set: rsp_data<=0, rsp_zero<=0, rsp_err<=1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_zero and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0 and go to IDLE. Holding for any number of cycles is legal.
  - alu_in1, alu_in2 and alu_op hold their values outside IDLE-accept edges.

Timing and throughput:
- Latency: accept edge T; result captured at T+1; rsp_valid high from T+2.
- Max throughput: one transaction per 3 cycles when rsp_ready is tied high.

Arbitration and handshake rules:
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- Requesters must hold req_valid and the payload stable until accepted; only payloads sampled on the accept edge matter.
- Lowering req_valid before grant withdraws the request without error.
- Simultaneous req_valid with rsp_valid: no accept until the response is consumed; req_ready stays 0 outside IDLE.
- Legal opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- Arithmetic and flag semantics belong to the ALU; this block neither extends, truncates nor reinterprets DW-bit values.

Decomposition:
- Shared package/header (def.v): `INTERNAL_BITS, `ALUOP_BITS, the six ALUop code constants, and the FSM state encodings IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- One sub-module: rr_arbiter. It is a parameterised NREQ-wide round-robin picker with inputs req vector and ptr, and outputs one-hot grant, grant index and any_req.
- The ALU itself is instantiated at the level above and connected by port.

Test Plan:
- Single request: reset; req_valid=4'b0001, op=0010, a=16'h0003, b=16'h0004 -> req_ready[0] for 1 cycle; at T+2 rsp_valid=1, rsp_id=0, rsp_data=16'h0007, rsp_err=0.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each response arrives 3 cycles after the previous one; rsp_id matches the grant.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_id/data/zero/err stable; req_ready stays 0; the next accept occurs in the cycle after rsp_ready=1 is sampled.
- Illegal op: requester 2 sends op=4'b1111 -> rsp_id=2, rsp_err=1, rsp_data=16'h0000, rsp_zero=0.
- Async reset in EXEC: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, no stale response appears; requester 0 has first priority.
- Zero flag pass-through: op=0110 (SUB), a=b=16'h1234 -> rsp_zero equals the sampled alu_zero, and rsp_data equals the sampled alu_result.
